nnrv_if_q: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, replacing the single-register fetch between instruction RAM and decode. It issues sequential reads to a RAM with configurable read latency and tracks each in-flight read with its PC. Returned instructions are buffered in a DEPTH-entry FIFO and handed to decode with a valid/ready handshake. A decode-side redirect flushes the queue, discards in-flight reads and restarts fetch at the jump target.

---
 rtl/nnrv_if_q.sv | 155 +++++++++++++++
 tb/tb_nnrv_if_q.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nnrv_if_q.sv
// Instruction-fetch stage with a credit-controlled prefetch queue between the
// instruction RAM and decode. Decode redirects flush the queue and all in-flight reads.
module nnrv_if_q #(
    parameter int          INSTR_WIDTH = 32,
    parameter int          ADDR_WIDTH  = 8,
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 4,
    parameter int          RD_LAT      = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [ADDR_WIDTH-1:0]  o_ram_rd_addr,
    output logic                   o_ram_rd_en,
    output logic [3:0]             o_ram_rd_mask,
    input  logic [INSTR_WIDTH-1:0] i_ram_rd_data,
    output logic                   o_id_valid,
    output logic [INSTR_WIDTH-1:0] o_id_instr,
    output logic [XLEN-1:0]        o_id_cur_pc,
    input  logic                   i_id_ready,
    input  logic                   i_id_jmp,
    input  logic [XLEN-1:0]        i_id_jmp_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(DEPTH + RD_LAT + 1);

    logic [XLEN-1:0]        r_fetch_pc;
    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [XLEN-1:0]        r_mem_pc    [DEPTH];
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic [RD_LAT-1:0]      r_pipe_vld;
    logic [XLEN-1:0]        r_pipe_pc   [RD_LAT];

    logic [SW-1:0]          w_inflight;
    logic                   w_credit;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_valid;

    // Count outstanding RAM reads; the returning stage still holds its credit.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + SW'(r_pipe_vld[i]);
        end
    end

    assign w_credit = (SW'(r_count) + w_inflight) < SW'(DEPTH);
    assign w_issue  = i_id_jmp | w_credit;
    assign w_valid  = (r_count != '0);
    assign w_push   = r_pipe_vld[RD_LAT-1] & ~i_id_jmp;
    assign w_pop    = w_valid & i_id_ready & ~i_id_jmp;

    assign o_ram_rd_en   = w_issue & ~i_rst;
    assign o_ram_rd_addr = i_id_jmp ? i_id_jmp_pc[ADDR_WIDTH-1:0] : r_fetch_pc[ADDR_WIDTH-1:0];
    assign o_ram_rd_mask = 4'b1111;

    assign o_id_valid  = w_valid;
    assign o_id_instr  = w_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign o_id_cur_pc = w_valid ? r_mem_pc[r_rd_ptr] : '0;

    // Fetch PC: a redirect restarts one word past the target, which issues this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_id_jmp) begin
            r_fetch_pc <= i_id_jmp_pc + XLEN'(4);
        end else if (w_credit) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end else begin
            r_fetch_pc <= r_fetch_pc;
        end
    end

    // In-flight read tracker; a redirect kills every older read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_pc[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_pc[0]  <= i_id_jmp ? i_id_jmp_pc : r_fetch_pc;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1] & ~i_id_jmp;
                r_pipe_pc[i]  <= r_pipe_pc[i-1];
            end
        end
    end

    // Queue bookkeeping; flush takes priority over push and pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_id_jmp) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= i_ram_rd_data;
            r_mem_pc[r_wr_ptr]    <= r_pipe_pc[RD_LAT-1];
        end
    end

    nnrv_if_q_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_count (r_count)
    );

endmodule

// Overflow guard: a return must never land in a full queue without a pop.
module nnrv_if_q_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [CW-1:0] i_count
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_push && !i_pop) |-> (i_count < CW'(DEPTH)));

endmodule

// File: tb/tb_nnrv_if_q.sv
// Directed bench for nnrv_if_q: instance A (RD_LAT=1, RESET_PC=0) and
// instance B (RD_LAT=2, RESET_PC=0xFFFF_FFFC) share stimulus; one is observed at a time.
module tb_nnrv_if_q;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jmp;
    logic [31:0] jpc;
    logic        sel;

    logic [7:0]  a_addr, b_addr;
    logic        a_en, b_en;
    logic [3:0]  a_mask, b_mask;
    logic [31:0] a_data, b_data;
    logic        a_vld, b_vld;
    logic [31:0] a_instr, b_instr, a_pc, b_pc;

    logic [7:0]  a_q;
    logic [7:0]  b_q0, b_q1;

    logic        m_vld, m_en;
    logic [7:0]  m_addr;
    logic [31:0] m_pc, m_instr;
    logic [3:0]  m_mask;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    nnrv_if_q #(.INSTR_WIDTH(32), .ADDR_WIDTH(8), .XLEN(32), .DEPTH(4), .RD_LAT(1),
                .RESET_PC(32'h0000_0000)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .o_ram_rd_addr(a_addr), .o_ram_rd_en(a_en),
        .o_ram_rd_mask(a_mask), .i_ram_rd_data(a_data), .o_id_valid(a_vld),
        .o_id_instr(a_instr), .o_id_cur_pc(a_pc), .i_id_ready(rdy),
        .i_id_jmp(jmp), .i_id_jmp_pc(jpc)
    );

    nnrv_if_q #(.INSTR_WIDTH(32), .ADDR_WIDTH(8), .XLEN(32), .DEPTH(4), .RD_LAT(2),
                .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .o_ram_rd_addr(b_addr), .o_ram_rd_en(b_en),
        .o_ram_rd_mask(b_mask), .i_ram_rd_data(b_data), .o_id_valid(b_vld),
        .o_id_instr(b_instr), .o_id_cur_pc(b_pc), .i_id_ready(rdy),
        .i_id_jmp(jmp), .i_id_jmp_pc(jpc)
    );

    function automatic logic [31:0] ram_word(input logic [7:0] addr);
        return {24'hC0FFEE, addr};
    endfunction

    // RAM models: data appears RD_LAT cycles after the address was presented.
    always @(posedge clk) begin
        a_q  <= a_addr;
        b_q0 <= b_addr;
        b_q1 <= b_q0;
    end
    assign a_data = ram_word(a_q);
    assign b_data = ram_word(b_q1);

    assign m_vld   = sel ? b_vld   : a_vld;
    assign m_en    = sel ? b_en    : a_en;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_pc    = sel ? b_pc    : a_pc;
    assign m_instr = sel ? b_instr : a_instr;
    assign m_mask  = sel ? b_mask  : a_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for a presented instruction, compare against the scoreboard, accept it.
    task automatic expect_pop(input string tag, output int waited);
        logic [31:0] e;
        waited = 0;
        while (!(m_vld === 1'b1) && waited < 8) begin
            nxt();
            waited++;
        end
        chk({tag, "_vld"}, {31'd0, m_vld}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_pc"}, m_pc, e);
        chk({tag, "_instr"}, m_instr, ram_word(e[7:0]));
        nxt();
    endtask

    initial begin
        int w;
        int n_iss;
        logic [7:0] iss [8];

        // ---------------- Instance A: RD_LAT=1 ----------------
        sel = 1'b0; rst = 1'b1; rdy = 1'b1; jmp = 1'b0; jpc = 32'd0;
        #2;
        chk("rst_rd_en", {31'd0, m_en}, 32'd0);
        chk("rst_vld", {31'd0, m_vld}, 32'd0);
        chk("rst_instr", m_instr, 32'd0);
        chk("rst_pc", m_pc, 32'd0);
        chk("rst_mask", {28'd0, m_mask}, 32'hF);

        @(negedge clk); rst = 1'b0; #1;
        chk("first_en", {31'd0, m_en}, 32'd1);
        chk("first_addr", {24'd0, m_addr}, 32'h00);
        exp_q.push_back(32'd0); exp_q.push_back(32'd4);
        exp_q.push_back(32'd8); exp_q.push_back(32'd12);
        nxt();
        chk("first_not_yet", {31'd0, m_vld}, 32'd0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            expect_pop("stream", w);
            chk("stream_lat", w, 32'd0);
        end

        // Backpressure: exactly DEPTH reads then stall
        @(negedge clk); rst = 1'b1; rdy = 1'b0; #1;
        @(negedge clk); rst = 1'b0; #1;
        n_iss = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_en === 1'b1 && n_iss < 8) begin
                iss[n_iss] = m_addr;
                n_iss++;
            end
            nxt();
        end
        chk("bp_issues", n_iss, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_addr", {24'd0, iss[i]}, 32'(i * 4));
        end
        chk("bp_full_vld", {31'd0, m_vld}, 32'd1);
        rdy = 1'b1; #1;
        chk("bp_no_credit_on_pop", {31'd0, m_en}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'(i * 4));
        end
        for (int i = 0; i < 6; i++) begin
            expect_pop("bp_drain", w);
            if (i < 4) chk("bp_drain_lat", w, 32'd0);
        end

        // Asynchronous reset between edges, then refetch from RESET_PC
        rst = 1'b1; #1;
        chk("arst_vld", {31'd0, m_vld}, 32'd0);
        chk("arst_en", {31'd0, m_en}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("arst_refetch_addr", {24'd0, m_addr}, 32'h00);
        chk("arst_refetch_en", {31'd0, m_en}, 32'd1);
        exp_q.push_back(32'd0); exp_q.push_back(32'd4);
        nxt();
        chk("arst_not_yet", {31'd0, m_vld}, 32'd0);
        nxt();
        for (int i = 0; i < 2; i++) begin
            expect_pop("arst_refetch", w);
            chk("arst_refetch_lat", w, 32'd0);
        end

        // Jump with ready=1 into a full queue
        @(negedge clk); rdy = 1'b0; #1;
        for (int c = 0; c < 8; c++) nxt();
        chk("jfull_stalled", {31'd0, m_en}, 32'd0);
        jmp = 1'b1; jpc = 32'h0000_0040; rdy = 1'b1; #1;
        chk("jfull_en", {31'd0, m_en}, 32'd1);
        chk("jfull_addr", {24'd0, m_addr}, 32'h40);
        @(negedge clk); jmp = 1'b0; #1;
        chk("jfull_flushed", {31'd0, m_vld}, 32'd0);
        exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
        nxt();
        for (int i = 0; i < 3; i++) begin
            expect_pop("jfull_tgt", w);
            chk("jfull_tgt_lat", w, 32'd0);
        end

        // ---------------- Instance B: RD_LAT=2, wrapping RESET_PC ----------------
        sel = 1'b1; rst = 1'b1; #1;
        chk("b_rst_vld", {31'd0, m_vld}, 32'd0);
        chk("b_rst_en", {31'd0, m_en}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("wrap_addr0", {24'd0, m_addr}, 32'hFC);
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        nxt();
        chk("wrap_addr1", {24'd0, m_addr}, 32'h00);
        chk("wrap_en1", {31'd0, m_en}, 32'd1);
        nxt();
        chk("wrap_not_yet", {31'd0, m_vld}, 32'd0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            expect_pop("wrap", w);
            chk("wrap_lat", w, 32'd0);
        end

        // Jump while two reads are in flight
        jmp = 1'b1; jpc = 32'h0000_0040; #1;
        chk("jinf_en", {31'd0, m_en}, 32'd1);
        chk("jinf_addr", {24'd0, m_addr}, 32'h40);
        exp_q.delete();
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        @(negedge clk); jmp = 1'b0; #1;
        chk("jinf_stale1", {31'd0, m_vld}, 32'd0);
        nxt();
        chk("jinf_stale2", {31'd0, m_vld}, 32'd0);
        nxt();
        for (int i = 0; i < 2; i++) begin
            expect_pop("jinf_tgt", w);
            chk("jinf_tgt_lat", w, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
